// File: rtl/ex_pkg.sv
// Shared types and constants for the RV64I execute stage.
// ALUOp/forward codes, ALU operation enum, WB/M bit indices, decoder.
package ex_pkg;

  localparam int XLEN_DEF = 64;
  localparam int REGW_DEF = 5;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam int M_BRANCH    = 2;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;

  // Encodings equal {inst[30], funct3} so R/I decode is a cast.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b1000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SRA  = 4'b1101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111
  } alu_op_e;

  function automatic alu_op_e alu_decode(
    input logic [1:0] aluop,
    input logic [3:0] funct
  );
    alu_op_e op;
    op = ALU_ADD;
    case (aluop)
      ALUOP_BR: op = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          4'b0000, 4'b1000, 4'b0001,
          4'b0010, 4'b0011, 4'b0100,
          4'b0101, 4'b1101, 4'b0110,
          4'b0111: op = alu_op_e'(funct);
          default: op = ALU_ADD;
        endcase
      end
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ex_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage.
// master = upstream/consumer side, slave = ex_stage.
interface ex_if #(
  parameter int XLEN = 64,
  parameter int REGW = 5
);
  logic            Stall;
  logic            Flush;
  logic [XLEN-1:0] Inst_Addr;
  logic [XLEN-1:0] ReadData1;
  logic [XLEN-1:0] ReadData2;
  logic [XLEN-1:0] ImmediateData;
  logic [REGW-1:0] RD;
  logic [3:0]      Funct;
  logic [1:0]      WB;
  logic [2:0]      M;
  logic [1:0]      ALUOp;
  logic            ALUSrc;
  logic [1:0]      ForwardA;
  logic [1:0]      ForwardB;
  logic [XLEN-1:0] MEMWB_Data;

  logic [XLEN-1:0] ALU_Result_Out;
  logic [XLEN-1:0] WriteData_Out;
  logic [XLEN-1:0] Branch_Target_Out;
  logic            PCSrc;
  logic [REGW-1:0] RD_Out;
  logic [1:0]      WB_Out;
  logic [2:0]      M_Out;
  logic            Valid_Out;

  modport master (
    output Stall, Flush, Inst_Addr,
    output ReadData1, ReadData2,
    output ImmediateData, RD, Funct,
    output WB, M, ALUOp, ALUSrc,
    output ForwardA, ForwardB, MEMWB_Data,
    input  ALU_Result_Out, WriteData_Out,
    input  Branch_Target_Out, PCSrc,
    input  RD_Out, WB_Out, M_Out, Valid_Out
  );

  modport slave (
    input  Stall, Flush, Inst_Addr,
    input  ReadData1, ReadData2,
    input  ImmediateData, RD, Funct,
    input  WB, M, ALUOp, ALUSrc,
    input  ForwardA, ForwardB, MEMWB_Data,
    output ALU_Result_Out, WriteData_Out,
    output Branch_Target_Out, PCSrc,
    output RD_Out, WB_Out, M_Out, Valid_Out
  );
endinterface

// File: rtl/ex_alu64.sv
// Combinational RV64I ALU: op_i, a_i, b_i in; y_o out.
// Shift amount is the low log2(XLEN) bits of b_i.
module alu64
  import ex_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  alu_op_e         op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] y_o
);
  localparam int SW = $clog2(XLEN);

  logic [SW-1:0] sh;
  assign sh = b_i[SW-1:0];

  always_comb begin
    y_o = '0;
    case (op_i)
      ALU_ADD:  y_o = a_i + b_i;
      ALU_SUB:  y_o = a_i - b_i;
      ALU_SLL:  y_o = a_i << sh;
      ALU_SLT:  y_o = {{(XLEN-1){1'b0}},
                       $signed(a_i) < $signed(b_i)};
      ALU_SLTU: y_o = {{(XLEN-1){1'b0}},
                       a_i < b_i};
      ALU_XOR:  y_o = a_i ^ b_i;
      ALU_SRL:  y_o = a_i >> sh;
      ALU_SRA:  y_o = $signed(a_i) >>> sh;
      ALU_OR:   y_o = a_i | b_i;
      ALU_AND:  y_o = a_i & b_i;
      default:  y_o = '0;
    endcase
  end
endmodule

// File: rtl/ex_stage.sv
// RV64I execute stage: forwarding, ALU, branch, EX/MEM register.
// Ports: clk, reset_n (async low), bus (ex_if.slave).
module ex_stage
  import ex_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int REGW = REGW_DEF
) (
  input logic clk,
  input logic reset_n,
  ex_if.slave bus
);
  logic [XLEN-1:0] alu_q, alu_d;
  logic [XLEN-1:0] wd_q, wd_d;
  logic [XLEN-1:0] bt_q, bt_d;
  logic            pcsrc_q, pcsrc_d;
  logic [REGW-1:0] rd_q;
  logic [1:0]      wb_q;
  logic [2:0]      m_q;
  logic            valid_q;

  logic [XLEN-1:0] op_a, op_b;
  logic            eq, lt, ltu, take;
  alu_op_e         aop;

  // EX/MEM source is our own registered result.
  always_comb begin
    op_a = bus.ReadData1;
    case (bus.ForwardA)
      FWD_EXMEM: op_a = alu_q;
      FWD_MEMWB: op_a = bus.MEMWB_Data;
      default:   op_a = bus.ReadData1;
    endcase
  end

  always_comb begin
    wd_d = bus.ReadData2;
    case (bus.ForwardB)
      FWD_EXMEM: wd_d = alu_q;
      FWD_MEMWB: wd_d = bus.MEMWB_Data;
      default:   wd_d = bus.ReadData2;
    endcase
  end

  assign op_b = bus.ALUSrc ? bus.ImmediateData : wd_d;
  assign aop  = alu_decode(bus.ALUOp, bus.Funct);

  alu64 #(.XLEN(XLEN)) u_alu (
    .op_i (aop),
    .a_i  (op_a),
    .b_i  (op_b),
    .y_o  (alu_d)
  );

  // Branch compares the forwarded rs2, never the immediate.
  assign eq  = op_a == wd_d;
  assign lt  = $signed(op_a) < $signed(wd_d);
  assign ltu = op_a < wd_d;

  always_comb begin
    take = 1'b0;
    case (bus.Funct[2:0])
      3'b000:  take = eq;
      3'b001:  take = !eq;
      3'b100:  take = lt;
      3'b101:  take = !lt;
      3'b110:  take = ltu;
      3'b111:  take = !ltu;
      default: take = 1'b0;
    endcase
  end

  assign pcsrc_d = take & bus.M[M_BRANCH];
  assign bt_d    = bus.Inst_Addr
                 + (bus.ImmediateData << 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_q   <= '0;
      wd_q    <= '0;
      bt_q    <= '0;
      pcsrc_q <= 1'b0;
      rd_q    <= '0;
      wb_q    <= '0;
      m_q     <= '0;
      valid_q <= 1'b0;
    end else if (bus.Flush) begin
      alu_q   <= '0;
      wd_q    <= '0;
      bt_q    <= '0;
      pcsrc_q <= 1'b0;
      rd_q    <= '0;
      wb_q    <= '0;
      m_q     <= '0;
      valid_q <= 1'b0;
    end else if (!bus.Stall) begin
      alu_q   <= alu_d;
      wd_q    <= wd_d;
      bt_q    <= bt_d;
      pcsrc_q <= pcsrc_d;
      rd_q    <= bus.RD;
      wb_q    <= bus.WB;
      m_q     <= bus.M;
      valid_q <= 1'b1;
    end
  end

  assign bus.ALU_Result_Out    = alu_q;
  assign bus.WriteData_Out     = wd_q;
  assign bus.Branch_Target_Out = bt_q;
  assign bus.PCSrc             = pcsrc_q;
  assign bus.RD_Out            = rd_q;
  assign bus.WB_Out            = wb_q;
  assign bus.M_Out             = m_q;
  assign bus.Valid_Out         = valid_q;
endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard testbench for ex_stage.
// Stimulus pushes expected EX/MEM state; monitor pops and compares.
module tb_ex_stage;
  logic clk = 1'b0;
  logic reset_n = 1'b0;

  ex_if #(.XLEN(64), .REGW(5)) bus ();

  ex_stage #(.XLEN(64), .REGW(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] alu;
    logic [63:0] wd;
    logic [63:0] bt;
    logic        pc;
    logic [4:0]  rd;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic        v;
  } exp_t;

  exp_t q[$];
  exp_t prev;
  exp_t zero_e;
  int checks = 0;
  int errors = 0;
  event chk_ev;

  function automatic exp_t mk(
    input logic [63:0] alu, wd, bt,
    input logic pc, input logic [4:0] rd,
    input logic [1:0] wb, input logic [2:0] m
  );
    exp_t e;
    e.alu = alu; e.wd = wd; e.bt = bt;
    e.pc = pc; e.rd = rd; e.wb = wb;
    e.m = m; e.v = 1'b1;
    return e;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic compare(input exp_t e);
    chk("alu",   bus.ALU_Result_Out, e.alu);
    chk("wdata", bus.WriteData_Out, e.wd);
    chk("btgt",  bus.Branch_Target_Out, e.bt);
    chk("pcsrc", 64'(bus.PCSrc), 64'(e.pc));
    chk("rd",    64'(bus.RD_Out), 64'(e.rd));
    chk("wb",    64'(bus.WB_Out), 64'(e.wb));
    chk("m",     64'(bus.M_Out), 64'(e.m));
    chk("valid", 64'(bus.Valid_Out), 64'(e.v));
  endtask

  initial begin
    forever begin
      @(posedge clk or chk_ev);
      #1;
      while (q.size() > 0) compare(q.pop_front());
    end
  end

  task automatic drive(
    input logic [63:0] pc, r1, r2, imm,
    input logic [4:0] rd, input logic [3:0] fn,
    input logic [1:0] wb, input logic [2:0] m,
    input logic [1:0] aop, input logic asrc,
    input logic [1:0] fa, fb,
    input logic [63:0] mw
  );
    bus.Inst_Addr = pc;
    bus.ReadData1 = r1;
    bus.ReadData2 = r2;
    bus.ImmediateData = imm;
    bus.RD = rd;
    bus.Funct = fn;
    bus.WB = wb;
    bus.M = m;
    bus.ALUOp = aop;
    bus.ALUSrc = asrc;
    bus.ForwardA = fa;
    bus.ForwardB = fb;
    bus.MEMWB_Data = mw;
  endtask

  task automatic edge_exp(input exp_t e);
    q.push_back(e);
    prev = e;
    @(posedge clk);
  endtask

  task automatic async_exp(input exp_t e);
    q.push_back(e);
    ->chk_ev;
    #2;
  endtask

  localparam logic [63:0] M1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] M2 = 64'hFFFF_FFFF_FFFF_FFFE;

  initial begin
    zero_e = '{alu: 64'h0, wd: 64'h0, bt: 64'h0, pc: 1'b0,
               rd: 5'h0, wb: 2'h0, m: 3'h0, v: 1'b0};
    bus.Stall = 1'b0;
    bus.Flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    @(negedge clk);
    async_exp(zero_e);
    @(negedge clk);
    reset_n = 1'b1;

    // ADD 5+7
    drive(0, 5, 7, 0, 3, 4'b0000, 2'b10, 3'b000,
          2'b10, 0, 2'b00, 2'b00, 0);
    edge_exp(mk(12, 7, 0, 0, 3, 2'b10, 0));

    // Async reset mid-cycle with nonzero outputs
    @(negedge clk);
    #2 reset_n = 1'b0;
    async_exp(zero_e);
    @(negedge clk);
    reset_n = 1'b1;
    edge_exp(mk(12, 7, 0, 0, 3, 2'b10, 0));

    // SUB 3-5
    @(negedge clk);
    drive(0, 3, 5, 0, 4, 4'b1000, 2'b10, 3'b000,
          2'b10, 0, 2'b00, 2'b00, 0);
    edge_exp(mk(M2, 5, 0, 0, 4, 2'b10, 0));

    // SRA
    @(negedge clk);
    drive(0, 64'h8000_0000_0000_0000, 4, 0, 5,
          4'b1101, 2'b10, 3'b000, 2'b10, 0,
          2'b00, 2'b00, 0);
    edge_exp(mk(64'hF800_0000_0000_0000, 4, 0, 0,
                5, 2'b10, 0));

    // SLL with shamt from low 6 bits (0x43 -> 3)
    @(negedge clk);
    drive(0, 1, 64'h43, 0, 6, 4'b0001, 2'b10, 3'b000,
          2'b10, 0, 2'b00, 2'b00, 0);
    edge_exp(mk(8, 64'h43, 0, 0, 6, 2'b10, 0));

    // SLT signed vs SLTU
    @(negedge clk);
    drive(0, M1, 1, 0, 7, 4'b0010, 2'b10, 3'b000,
          2'b10, 0, 2'b00, 2'b00, 0);
    edge_exp(mk(1, 1, 0, 0, 7, 2'b10, 0));
    @(negedge clk);
    drive(0, M1, 1, 0, 7, 4'b0011, 2'b10, 3'b000,
          2'b10, 0, 2'b00, 2'b00, 0);
    edge_exp(mk(0, 1, 0, 0, 7, 2'b10, 0));

    // Produce 100, then forward it (A) plus MEMWB (B)
    @(negedge clk);
    drive(0, 60, 40, 0, 8, 4'b0000, 2'b10, 3'b000,
          2'b10, 0, 2'b00, 2'b00, 0);
    edge_exp(mk(100, 40, 0, 0, 8, 2'b10, 0));
    @(negedge clk);
    drive(0, 999, 888, 0, 9, 4'b0000, 2'b10, 3'b000,
          2'b10, 0, 2'b10, 2'b01, 20);
    edge_exp(mk(120, 20, 0, 0, 9, 2'b10, 0));

    // ForwardA=11 acts as 00; ALUOp 00 add
    @(negedge clk);
    drive(0, 1, 2, 0, 10, 4'b1000, 2'b10, 3'b000,
          2'b00, 0, 2'b11, 2'b11, 50);
    edge_exp(mk(3, 2, 0, 0, 10, 2'b10, 0));

    // beq taken
    @(negedge clk);
    drive(64'h1000, 9, 9, 8, 0, 4'b0000, 2'b00,
          3'b100, 2'b01, 0, 2'b00, 2'b00, 0);
    edge_exp(mk(0, 9, 64'h1010, 1, 0, 0, 3'b100));

    // Stall 2 cycles with changing inputs: hold
    @(negedge clk);
    bus.Stall = 1'b1;
    drive(64'h2000, 1, 2, 3, 11, 4'b0001, 2'b11,
          3'b010, 2'b10, 1, 2'b10, 2'b01, 77);
    edge_exp(prev);
    @(negedge clk);
    bus.ReadData1 = 64'h55;
    edge_exp(prev);

    // Stall + Flush: bubble
    @(negedge clk);
    bus.Flush = 1'b1;
    edge_exp(zero_e);
    @(negedge clk);
    bus.Flush = 1'b0;
    bus.Stall = 1'b0;

    // beq not taken
    drive(64'h1000, 9, 5, 8, 0, 4'b0000, 2'b00,
          3'b100, 2'b01, 0, 2'b00, 2'b00, 0);
    edge_exp(mk(4, 5, 64'h1010, 0, 0, 0, 3'b100));

    // blt signed taken
    @(negedge clk);
    drive(64'h100, M1, 1, 64'h20, 0, 4'b0100, 2'b00,
          3'b100, 2'b01, 0, 2'b00, 2'b00, 0);
    edge_exp(mk(M2, 1, 64'h140, 1, 0, 0, 3'b100));

    // bltu not taken; target wraps to 0
    @(negedge clk);
    drive(64'hFFFF_FFFF_FFFF_FFF0, M1, 1, 8, 0,
          4'b0110, 2'b00, 3'b100, 2'b01, 0,
          2'b00, 2'b00, 0);
    edge_exp(mk(M2, 1, 0, 0, 0, 0, 3'b100));

    // funct3 010 never taken even when equal
    @(negedge clk);
    drive(0, 9, 9, 0, 0, 4'b0010, 2'b00, 3'b100,
          2'b01, 0, 2'b00, 2'b00, 0);
    edge_exp(mk(0, 9, 0, 0, 0, 0, 3'b100));

    // sw: address = A + imm, store data = FB
    @(negedge clk);
    drive(64'h40, 64'h200, 64'hDEAD, 16, 0, 4'b0010,
          2'b00, 3'b001, 2'b00, 1, 2'b00, 2'b00, 0);
    edge_exp(mk(64'h210, 64'hDEAD, 64'h60, 0, 0,
                0, 3'b001));

    // Flush alone clears a valid entry
    @(negedge clk);
    bus.Flush = 1'b1;
    edge_exp(zero_e);
    @(negedge clk);
    bus.Flush = 1'b0;

    repeat (4) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      errors += q.size();
      $display("FAIL drain: got %0d pending expected 0",
               q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
